cla_pipe: RTL and testbench
===========================

Name: cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the combinational 32-bit cla32.
- Splits a WIDTH-bit add into STAGES chunks. Each chunk is a CLA block.
- The inter-chunk carry is registered, which shortens the critical path for the multi-cycle datapath and the PC/branch-target adders.
- Adds sub mode, status flags and a valid/ready handshake with backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, number of pipeline chunks. Must be ≥1 and divide WIDTH exactly; chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+ci; 1: a−b (a+~b+1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- co  output  1  raw carry-out of MSB. In sub mode, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  s == 0.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-low (rst_n), sampled on the rising edge of clk.
- Reset:
  - All stage valid bits clear, so out_valid=0.
  - s=0, co=0, ovf=0, zero=0; all skew/partial-sum registers cleared.
  - in_ready=1 during and after reset.
  - Reset mid-operation discards every in-flight operation; no result for them is ever presented.
- Operand conditioning at acceptance: b_eff = sub ? ~b : b; c0 = sub ? 1 : ci.
- Pipeline:
  - Stage k (k=1..STAGES) holds a valid bit, the registered carry c_k, the partial sum bits [k*CW−1:0], and the unprocessed high slices of a and b_eff.
  - On acceptance (in_valid && in_ready at the edge), stage 1 captures chunk 0 = CLA(a[CW−1:0], b_eff[CW−1:0], c0), its carry-out, and the skewed upper operand bits.
  - Each advancing edge, stage k+1 computes chunk k from stage k's carry.
  - Stage STAGES is the output register. It drives s, co, ovf and zero directly; no combinational path runs from a, b or ci to the outputs.
  - ovf and zero are computed in the final chunk's cycle and registered with s.
- Latency and throughput:
  - Accepted at edge N → out_valid=1 after edge N+STAGES−1, i.e. STAGES cycles.
  - Throughput is one operation per cycle while unstalled.
  - STAGES=1 degenerates to a fully registered single-cycle adder with latency 1.
- Handshake:
  - stall = out_valid && !out_ready. in_ready = !stall.
  - When stall is high, every stage register holds: no advance, no acceptance.
  - A result is consumed at an edge where out_valid && out_ready.
  - Bubbles (invalid stages) advance normally. Stage valid bits shift, so no pipeline holes are compressed and order is strictly FIFO.
- Simultaneous accept and consume in the same cycle is legal; the pipeline simply advances.
- Output stability: while out_valid && !out_ready, s, co, ovf and zero are held bit-stable.
- in_valid with in_ready=0: the operands are not captured. The producer must hold them (standard valid/ready).
- Arithmetic wraps modulo 2^WIDTH; co carries the lost bit.

Test Plan:
- WIDTH=32, STAGES=4: a=0, b=4, ci=0, sub=0 → after 4 cycles s=0x00000004, co=0, ovf=0, zero=0 (PC+4 check).
- a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0 → s=0x00000000, co=1, ovf=0, zero=1. This exercises carry propagation through all 4 registered chunk boundaries.
- Signed/sub cases:
  - a=0x7FFFFFFF, b=1, sub=0 → s=0x80000000, ovf=1, co=0.
  - a=5, b=7, sub=1 (ci=1 ignored) → s=0xFFFFFFFE, co=0, ovf=0.
  - a=0x80000000, b=1, sub=1 → s=0x7FFFFFFF, ovf=1, co=1.
- Backpressure:
  - Stream 8 back-to-back ops (a=i, b=i) with out_ready=0 from cycle 5.
  - Required: out_valid=1 with s=0 held stable; in_ready=0.
  - Then release out_ready: results 0,2,4,…,14 emerge in order, one per cycle, none lost or duplicated.
- Reset mid-operation: issue 3 ops, then drive rst_n=0 for one edge → out_valid=0 next cycle, s=0. No stale results appear over the following 8 cycles with in_valid=0.
- Parameter sweep: STAGES ∈ {1,2,8,32} at WIDTH=32, plus WIDTH=16/STAGES=4, with 10k random a/b/ci/sub and random out_ready against a reference model → exact s/co/ovf/zero match, latency = STAGES when unstalled.

Source files
------------

// File: rtl/cla_pipe.sv
// rtl/cla_pipe.sv - pipelined carry-lookahead adder/subtractor, one CLA chunk per stage
// Inter-chunk carry is registered; valid/ready handshake with full-pipeline stall.
module cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  // returns {carry into chunk MSB, carry out, sum}
  function automatic logic [CW+1:0] cla(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                        input logic cin);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   c;
    logic          pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CW; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int k = i - 1; k >= 0; k--) begin
        c[i+1] = c[i+1] | (pp & g[k]);
        pp     = pp & p[k];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    return {c[CW-1], c[CW], p ^ c[CW-1:0]};
  endfunction

  logic             v_q  [1:STAGES];
  logic             c_q  [1:STAGES];
  logic [WIDTH-1:0] a_q  [1:STAGES];
  logic [WIDTH-1:0] b_q  [1:STAGES];
  logic [WIDTH-1:0] ps_q [1:STAGES];
  logic             ovf_q;
  logic             zero_q;

  // src_*[j] feed the chunk-j logic: index 0 is the conditioned input, j>0 is stage j
  logic             src_v  [0:STAGES-1];
  logic             src_c  [0:STAGES-1];
  logic [WIDTH-1:0] src_a  [0:STAGES-1];
  logic [WIDTH-1:0] src_b  [0:STAGES-1];
  logic [WIDTH-1:0] src_ps [0:STAGES-1];
  logic [CW+1:0]    nx_r   [0:STAGES-1];
  logic [WIDTH-1:0] nx_ps  [0:STAGES-1];

  logic stall;

  assign out_valid = v_q[STAGES];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign s         = ps_q[STAGES];
  assign co        = c_q[STAGES];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    src_v[0]  = in_valid;
    src_c[0]  = sub | ci;
    src_a[0]  = a;
    src_b[0]  = sub ? ~b : b;
    src_ps[0] = '0;
    for (int j = 1; j < STAGES; j++) begin
      src_v[j]  = v_q[j];
      src_c[j]  = c_q[j];
      src_a[j]  = a_q[j];
      src_b[j]  = b_q[j];
      src_ps[j] = ps_q[j];
    end
    for (int j = 0; j < STAGES; j++) begin
      nx_r[j]               = cla(src_a[j][j*CW +: CW], src_b[j][j*CW +: CW], src_c[j]);
      nx_ps[j]              = src_ps[j];
      nx_ps[j][j*CW +: CW]  = nx_r[j][CW-1:0];
    end
  end

  // Data registers load only behind a valid token, so outputs hold their last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 1; j <= STAGES; j++) begin
        v_q[j]  <= 1'b0;
        c_q[j]  <= 1'b0;
        a_q[j]  <= '0;
        b_q[j]  <= '0;
        ps_q[j] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int j = 1; j <= STAGES; j++) begin
        v_q[j] <= src_v[j-1];
        if (src_v[j-1]) begin
          c_q[j]  <= nx_r[j-1][CW];
          a_q[j]  <= src_a[j-1];
          b_q[j]  <= src_b[j-1];
          ps_q[j] <= nx_ps[j-1];
        end
      end
      if (src_v[STAGES-1]) begin
        ovf_q  <= nx_r[STAGES-1][CW+1] ^ nx_r[STAGES-1][CW];
        zero_q <= (nx_ps[STAGES-1] == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe.sv
// tb/tb_cla_pipe.sv - directed and randomized checks of cla_pipe over several WIDTH/STAGES
module tb_cla_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, ci, sub, out_ready;
  logic [31:0] a, b;
  logic [5:0]  ov, ir, co, ovf, zr;
  logic [31:0] s0, s1, s2, s3, s4;
  logic [15:0] s5;

  cla_pipe #(.WIDTH(32), .STAGES(4)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[0]), .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[0]),
    .out_ready(out_ready), .s(s0), .co(co[0]), .ovf(ovf[0]), .zero(zr[0]));
  cla_pipe #(.WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[1]), .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[1]),
    .out_ready(out_ready), .s(s1), .co(co[1]), .ovf(ovf[1]), .zero(zr[1]));
  cla_pipe #(.WIDTH(32), .STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[2]), .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[2]),
    .out_ready(out_ready), .s(s2), .co(co[2]), .ovf(ovf[2]), .zero(zr[2]));
  cla_pipe #(.WIDTH(32), .STAGES(8)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[3]), .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[3]),
    .out_ready(out_ready), .s(s3), .co(co[3]), .ovf(ovf[3]), .zero(zr[3]));
  cla_pipe #(.WIDTH(32), .STAGES(32)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[4]), .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[4]),
    .out_ready(out_ready), .s(s4), .co(co[4]), .ovf(ovf[4]), .zero(zr[4]));
  cla_pipe #(.WIDTH(16), .STAGES(4)) u5 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir[5]), .a(a[15:0]), .b(b[15:0]), .ci(ci), .sub(sub), .out_valid(ov[5]),
    .out_ready(out_ready), .s(s5), .co(co[5]), .ovf(ovf[5]), .zero(zr[5]));

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
    int          stamp;
  } exp_t;

  exp_t q [6][$];
  int   adv_cnt [6];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int stg(input int i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      4: return 32;
      default: return 4;
    endcase
  endfunction

  function automatic int wid(input int i);
    return (i == 5) ? 16 : 32;
  endfunction

  function automatic logic [31:0] sget(input int i);
    case (i)
      0: return s0;
      1: return s1;
      2: return s2;
      3: return s3;
      4: return s4;
      default: return {16'd0, s5};
    endcase
  endfunction

  // plain w-bit two's-complement arithmetic
  function automatic exp_t model(input int w, input logic [31:0] a_, input logic [31:0] b_,
                                 input logic ci_, input logic sub_);
    exp_t        e;
    logic [63:0] mask, aa, bb, sm;
    mask   = (64'd1 << w) - 64'd1;
    aa     = {32'd0, a_} & mask;
    bb     = (sub_ ? ~{32'd0, b_} : {32'd0, b_}) & mask;
    sm     = aa + bb + (sub_ ? 64'd1 : {63'd0, ci_});
    e.s    = sm[31:0] & mask[31:0];
    e.co   = sm[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
    e.zero = ((sm & mask) == 64'd0);
    e.stamp = 0;
    return e;
  endfunction

  task automatic do_op(input string tag, input logic [31:0] a_, input logic [31:0] b_,
                       input logic ci_, input logic sub_, input logic [31:0] es,
                       input logic eco, input logic eovf, input logic ez);
    int lat;
    @(negedge clk);
    a = a_; b = b_; ci = ci_; sub = sub_; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_s"}, s0, es);
    check({tag, "_co"}, co[0], eco);
    check({tag, "_ovf"}, ovf[0], eovf);
    check({tag, "_zero"}, zr[0], ez);
  endtask

  task automatic rnd_cycle(input logic iv, input logic ordy);
    logic exp_vld, stall;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    case ($urandom_range(0, 3))
      0:       b = ~a;
      1:       b = -a;
      default: b = $urandom;
    endcase
    ci  = $urandom_range(0, 1);
    sub = $urandom_range(0, 1);
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_vld = (q[i].size() > 0) && ((adv_cnt[i] - q[i][0].stamp) >= stg(i));
      stall   = exp_vld && !out_ready;
      check($sformatf("u%0d_valid", i), ov[i], exp_vld);
      check($sformatf("u%0d_ready", i), ir[i], !stall);
      if (exp_vld) begin
        e = q[i][0];
        check($sformatf("u%0d_s", i), sget(i), e.s);
        check($sformatf("u%0d_co", i), co[i], e.co);
        check($sformatf("u%0d_ovf", i), ovf[i], e.ovf);
        check($sformatf("u%0d_zero", i), zr[i], e.zero);
        if (out_ready) void'(q[i].pop_front());
      end
      if (!stall) begin
        if (in_valid) begin
          e = model(wid(i), a, b, ci, sub);
          e.stamp = adv_cnt[i];
          q[i].push_back(e);
        end
        adv_cnt[i]++;
      end
    end
  endtask

  initial begin
    int sent;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", ov[0], 1'b0);
    check("rst_ready", ir[0], 1'b1);
    check("rst_s", s0, 32'd0);
    check("rst_co", co[0], 1'b0);
    check("rst_ovf", ovf[0], 1'b0);
    check("rst_zero", zr[0], 1'b0);
    rst_n = 1'b1;

    do_op("pc4",   32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    do_op("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op("sovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op("sub57", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("subov", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // backpressure: fill, stall, then drain in order one per cycle
    repeat (6) @(negedge clk);
    sent = 0; ci = 1'b0; sub = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      @(negedge clk);
      in_valid = 1'b1; a = sent; b = sent; out_ready = 1'b1;
      #1;
      if (ir[0]) sent++;
    end
    check("bp_filled", sent, 4);
    for (int ph = 0; ph < 4; ph++) begin
      @(negedge clk);
      in_valid = 1'b1; a = sent; b = sent; out_ready = 1'b0;
      #1;
      check("bp_hold_valid", ov[0], 1'b1);
      check("bp_hold_s", s0, 32'd0);
      check("bp_hold_ready", ir[0], 1'b0);
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      in_valid = (sent < 8); a = sent; b = sent; out_ready = 1'b1;
      #1;
      check("bp_drain_valid", ov[0], 1'b1);
      check("bp_drain_s", s0, 2 * r);
      if (in_valid && ir[0]) sent++;
    end
    check("bp_sent", sent, 8);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_empty", ov[0], 1'b0);

    // reset with three operations in flight
    repeat (40) @(negedge clk);
    for (int ph = 0; ph < 3; ph++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 100 + ph; b = 1; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_valid", ov[0], 1'b0);
    check("mrst_s", s0, 32'd0);
    for (int ph = 0; ph < 8; ph++) begin
      @(negedge clk);
      #1;
      check("mrst_no_stale", ov, 6'd0);
    end

    // randomized sweep across all instances
    for (int i = 0; i < 6; i++) adv_cnt[i] = 0;
    for (int n = 0; n < 10000; n++)
      rnd_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    for (int n = 0; n < 60; n++)
      rnd_cycle(1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      check($sformatf("u%0d_drained", i), q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
